// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: segment bit positions,
// the hex-to-segment table and the all-dark LED pattern.
package seg7_pkg;

  // Bit positions inside the {dp,g,f,e,d,c,b,a} segment byte.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-low pins: all ones means every segment/digit is off.
  localparam logic [7:0] LED_OFF = 8'hFF;

  // Active-high gfedcba pattern per hex value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-high gfedcba segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Straight table lookup.
  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/seg7_scan_multi.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with PWM brightness,
// per-digit dp/blank/blink and a double-buffered valid/ready update port.
module seg7_scan_multi
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned SCAN_LOG2    = 16,
  parameter int unsigned BRIGHT_W     = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [N_DIGITS-1:0]   led_en,
  output logic [7:0]            led_seg,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

  logic [SCAN_LOG2-1:0]  tick_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  frame_start_q;
  logic [BC_W-1:0]       blink_cnt_q;
  logic                  blink_phase_q;
  logic                  pending_q;
  logic [4*N_DIGITS-1:0] sh_hex_q, act_hex_q;
  logic [N_DIGITS-1:0]   sh_dp_q, sh_blank_q, sh_blink_q;
  logic [N_DIGITS-1:0]   act_dp_q, act_blank_q, act_blink_q;
  logic [N_DIGITS-1:0]   led_en_q;
  logic [7:0]            led_seg_q;

  logic                  slot_end, frame_wrap, accept;
  logic [3:0]            hex_sel;
  logic [6:0]            dec_seg;
  logic [7:0]            seg_on;
  logic [BRIGHT_W-1:0]   pwm_phase;
  logic                  lit, show;
  logic [N_DIGITS-1:0]   en_onehot;

  // Scan position, frame boundary and handshake qualifiers.
  always_comb begin
    slot_end   = &tick_q;
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    accept     = upd_valid && !pending_q;
    hex_sel    = act_hex_q[{idx_q, 2'b00} +: 4];
  end

  seg7_hex_decode u_dec (
    .hex (hex_sel),
    .seg (dec_seg)
  );

  // PWM gating, per-digit visibility and the selected digit's pin patterns.
  always_comb begin
    pwm_phase = tick_q[SCAN_LOG2-1 -: BRIGHT_W];
    lit       = (&bright) || (pwm_phase < bright);
    show      = lit && !act_blank_q[idx_q] && !(act_blink_q[idx_q] && blink_phase_q);
    en_onehot = '0;
    en_onehot[idx_q] = 1'b1;
    seg_on = {1'b0, dec_seg};
    seg_on[SEG_DP] = act_dp_q[idx_q];
  end

  // Slot/digit counters, frame pulse and blink timebase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q        <= '0;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      tick_q        <= tick_q + SCAN_LOG2'(1);
      frame_start_q <= frame_wrap;
      if (slot_end) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      // Counting wraps keeps blink_phase aligned with the first slot of a frame.
      if (frame_wrap) begin
        if (blink_cnt_q == BC_LAST) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BC_W'(1);
        end
      end
    end
  end

  // Shadow capture on handshake; shadow->active only at a frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= 1'b0;
      sh_hex_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_blink_q  <= '0;
      act_hex_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      act_blink_q <= '0;
    end else begin
      // accept needs pending=0 and the copy needs pending=1, so they never collide.
      if (frame_wrap && pending_q) begin
        act_hex_q   <= sh_hex_q;
        act_dp_q    <= sh_dp_q;
        act_blank_q <= sh_blank_q;
        act_blink_q <= sh_blink_q;
        pending_q   <= 1'b0;
      end
      if (accept) begin
        sh_hex_q   <= hex_in;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank_in;
        sh_blink_q <= blink_in;
        pending_q  <= 1'b1;
      end
    end
  end

  // Registered active-low pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_en_q  <= '1;
      led_seg_q <= LED_OFF;
    end else begin
      led_en_q  <= show ? ~en_onehot : '1;
      led_seg_q <= show ? ~seg_on : LED_OFF;
    end
  end

  assign upd_ready   = !pending_q;
  assign led_en      = led_en_q;
  assign led_seg     = led_seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_multi.sv
// Self-checking bench for seg7_scan_multi (4 digits, 8-cycle slots, 2-bit PWM,
// 2-frame blink half-period).
module tb_seg7_scan_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] hex_in;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic [1:0]  bright;
  logic [3:0]  led_en;
  logic [7:0]  led_seg;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] en;
    logic [7:0] seg;
    logic       fs;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [1:0]  br;
    logic [31:0] segs;  // expected active-low seg byte per digit, {d3,d2,d1,d0}
  } vec_t;
  vec_t vecs[6];

  seg7_scan_multi #(
    .N_DIGITS     (4),
    .SCAN_LOG2    (3),
    .BRIGHT_W     (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .hex_in      (hex_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .blink_in    (blink_in),
    .bright      (bright),
    .led_en      (led_en),
    .led_seg     (led_seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge of a frame_start cycle; checks the following 32 cycles.
  task automatic expect_frame(input logic [31:0] segs, input logic [3:0] blank,
                              input logic [3:0] blink, input logic bph, input logic [1:0] br);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      int  d;
      int  t;
      logic show;
      d    = k / 8;
      t    = k % 8;
      show = ((br == 2'd3) || ((t / 2) < br)) && !blank[d] && !(blink[d] && bph);
      e.en  = show ? ~(4'b0001 << d) : 4'hF;
      e.seg = show ? segs[8*d +: 8] : 8'hFF;
      e.fs  = (k == 31);
      sb.push_back(e);
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) upd_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if ({led_en, led_seg, frame_start} !== {e.en, e.seg, e.fs}) begin
        n_err++;
        $display("FAIL frame k=%0d: got en=%h seg=%h fs=%b expected en=%h seg=%h fs=%b",
                 k, led_en, led_seg, frame_start, e.en, e.seg, e.fs);
      end
    end
  endtask

  // Offer content and return at the negedge after it was accepted.
  task automatic offer(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b,
                       input logic [3:0] k);
    bit done = 1'b0;
    hex_in = h; dp_in = d; blank_in = b; blink_in = k;
    upd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (upd_ready) done = 1'b1;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    if (!done) check("offer_timeout", 32'd0, 32'd1);
  endtask

  // Wait for pending content to be applied; that must coincide with frame_start.
  task automatic wait_applied();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (upd_ready) done = 1'b1;
    end
    if (!done) check("apply_timeout", 32'd0, 32'd1);
    else check("apply_at_frame_start", 32'(frame_start), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lit_cnt;

    vecs[0] = '{hex: 16'h1234, dp: 4'b0000, blank: 4'b0000, br: 2'd3, segs: 32'hF9A4B099};
    vecs[1] = '{hex: 16'hABCD, dp: 4'b0101, blank: 4'b0000, br: 2'd3, segs: 32'h8803A721};
    vecs[2] = '{hex: 16'h0F89, dp: 4'b0000, blank: 4'b0100, br: 2'd1, segs: 32'hC0FF8098};
    vecs[3] = '{hex: 16'h5E76, dp: 4'b0000, blank: 4'b0000, br: 2'd2, segs: 32'h9286F882};
    vecs[4] = '{hex: 16'h5670, dp: 4'b1000, blank: 4'b0000, br: 2'd0, segs: 32'hFFFFFFFF};
    vecs[5] = '{hex: 16'hE6E5, dp: 4'b0000, blank: 4'b1111, br: 2'd3, segs: 32'hFFFFFFFF};

    rst = 1'b1; upd_valid = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0; blink_in = '0;
    bright = 2'd3;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_led_en", 32'(led_en), 32'hF);
    check("rst_led_seg", 32'(led_seg), 32'hFF);
    check("rst_upd_ready", 32'(upd_ready), 32'd1);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;

    // First frame is dark and frame_start first appears 32 cycles after release.
    n = 0; lit_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (led_en != 4'hF) lit_cnt++;
      n = i;
      if (frame_start) break;
    end
    check("first_frame_start_cycle", 32'(n), 32'd32);
    check("dark_before_update", 32'(lit_cnt), 32'd0);

    // Second offer while pending is held off until the frame wrap.
    hex_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; blink_in = 4'b0000;
    upd_valid = 1'b1;
    @(negedge clk);
    check("ready_low_when_pending", 32'(upd_ready), 32'd0);
    hex_in = 16'hABCD; dp_in = 4'b0101;
    repeat (5) @(negedge clk);
    check("ready_stays_low", 32'(upd_ready), 32'd0);
    wait_applied();
    expect_frame(32'hF9A4B099, 4'b0000, 4'b0000, 1'b0, 2'd3);
    check("ready_after_wrap", 32'(upd_ready), 32'd1);
    expect_frame(32'h8803A721, 4'b0000, 4'b0000, 1'b0, 2'd3);

    // Acceptance in the wrap cycle lands in shadow only: one more old frame first.
    repeat (31) @(negedge clk);
    hex_in = 16'h5E76; dp_in = 4'b0000; blank_in = 4'b0000; blink_in = 4'b0000;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    check("wrap_accept_fs", 32'(frame_start), 32'd1);
    check("wrap_accept_pending", 32'(upd_ready), 32'd0);
    expect_frame(32'h8803A721, 4'b0000, 4'b0000, 1'b0, 2'd3);
    check("wrap_accept_applied", 32'(upd_ready), 32'd1);
    expect_frame(32'h9286F882, 4'b0000, 4'b0000, 1'b0, 2'd3);

    // Table of display contents and brightness levels.
    foreach (vecs[i]) begin
      bright = vecs[i].br;
      offer(vecs[i].hex, vecs[i].dp, vecs[i].blank, 4'b0000);
      wait_applied();
      expect_frame(vecs[i].segs, vecs[i].blank, 4'b0000, 1'b0, vecs[i].br);
    end

    // Blink on digit 0, dp on digit 1, from a fresh reset so the blink phase is known.
    bright = 2'd3;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    offer(16'h1234, 4'b0010, 4'b0000, 4'b0001);
    wait_applied();
    expect_frame(32'hF9A43099, 4'b0000, 4'b0001, 1'b0, 2'd3);
    expect_frame(32'hF9A43099, 4'b0000, 4'b0001, 1'b1, 2'd3);
    expect_frame(32'hF9A43099, 4'b0000, 4'b0001, 1'b1, 2'd3);
    expect_frame(32'hF9A43099, 4'b0000, 4'b0001, 1'b0, 2'd3);

    // Asynchronous reset mid-slot with an update pending.
    hex_in = 16'hFFFF; dp_in = 4'b0000; blank_in = 4'b0000; blink_in = 4'b0000;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_digit1_on", 32'(led_en), 32'hD);
    check("pre_reset_pending", 32'(upd_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led_en", 32'(led_en), 32'hF);
    check("async_rst_led_seg", 32'(led_seg), 32'hFF);
    check("async_rst_ready", 32'(upd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    lit_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (led_en != 4'hF || led_seg != 8'hFF) lit_cnt++;
    end
    check("dark_after_reset", 32'(lit_cnt), 32'd0);
    check("ready_after_reset", 32'(upd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
